// File: rtl/fan_ctrl_pkg.sv
// Shared types and default parameters for the fan ramp controller.
// FAN_KICK_EN adds the KICK state and its default duration.
package fan_ctrl_pkg;

  localparam int SPEED_W       = 12;
  localparam int RAMP_DIV_DEF  = 2500;
  localparam int STEP_DEF      = 4;
  localparam int SPEED_MAX_DEF = 100;
`ifdef FAN_KICK_EN
  localparam int KICK_CYCLES_DEF = 250000;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1
`ifdef FAN_KICK_EN
    ,
    ST_KICK = 2'd2
`endif
  } fan_state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// Step divider: counts 0..RAMP_DIV-1 and pulses tick on the last count.
// clear holds the count at 0 and suppresses tick.
module ramp_tick_gen
  import fan_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = RAMP_DIV_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(RAMP_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Fan speed ramp controller: moves speed toward a requested target in STEP
// increments every RAMP_DIV clocks. FAN_KICK_EN adds a full-speed kick start.
module fan_ramp_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int RAMP_DIV  = RAMP_DIV_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int SPEED_MAX = SPEED_MAX_DEF
`ifdef FAN_KICK_EN
  ,
  parameter int KICK_CYCLES = KICK_CYCLES_DEF
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  input  logic [SPEED_W-1:0] req_speed,
  output logic               req_ready,
  output logic [SPEED_W-1:0] speed,
  output logic               busy,
  output logic               at_target,
  output fan_state_e         state_dbg
);

  // Handshake: a request is taken on any rising edge where req_valid and
  // req_ready are both high; req_speed is only meaningful while req_valid is.

  localparam logic [SPEED_W-1:0] SMAX   = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] STEP_C = SPEED_W'(STEP);

  fan_state_e         state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic [SPEED_W-1:0] req_clamped;
  logic [SPEED_W-1:0] step_val;
  logic               accept;
  logic               tick_clear;
  logic               step;

`ifdef FAN_KICK_EN
  localparam int          KW        = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_CYCLES - 1);
  logic [KW-1:0] kick_q, kick_d;
`endif

  assign accept      = req_valid && req_ready;
  assign req_clamped = (req_speed > SMAX) ? SMAX : req_speed;

  // A new request restarts the divider so the first step is a full period away.
  assign tick_clear = accept || (state_q != ST_RAMP);

  ramp_tick_gen #(
    .RAMP_DIV(RAMP_DIV)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clear(tick_clear),
    .tick (step)
  );

  // Differences are compared before stepping so the result cannot overshoot or wrap.
  always_comb begin
    step_val = speed_q;
    if (speed_q < target_q) begin
      step_val = ((target_q - speed_q) <= STEP_C) ? target_q : speed_q + STEP_C;
    end else if (speed_q > target_q) begin
      step_val = ((speed_q - target_q) <= STEP_C) ? target_q : speed_q - STEP_C;
    end
  end

  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    target_d = target_q;
`ifdef FAN_KICK_EN
    kick_d   = kick_q;
`endif
    case (state_q)
      ST_IDLE, ST_RAMP: begin
        if (accept) begin
          target_d = req_clamped;
`ifdef FAN_KICK_EN
          if ((speed_q == '0) && (req_clamped != '0)) begin
            state_d = ST_KICK;
            speed_d = SMAX;
            kick_d  = '0;
          end else
`endif
          begin
            state_d = (req_clamped == speed_q) ? ST_IDLE : ST_RAMP;
          end
        end else if (state_q == ST_RAMP) begin
          if (speed_q == target_q) begin
            state_d = ST_IDLE;
          end else if (step) begin
            speed_d = step_val;
          end
        end
      end
`ifdef FAN_KICK_EN
      ST_KICK: begin
        if (kick_q == KICK_LAST) begin
          state_d = ST_IDLE;
          speed_d = target_q;
          kick_d  = '0;
        end else begin
          kick_d = kick_q + KW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      speed_q  <= '0;
      target_q <= '0;
`ifdef FAN_KICK_EN
      kick_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      target_q <= target_d;
`ifdef FAN_KICK_EN
      kick_q   <= kick_d;
`endif
    end
  end

`ifdef FAN_KICK_EN
  assign req_ready = (state_q != ST_KICK);
`else
  assign req_ready = 1'b1;
`endif
  assign speed     = speed_q;
  assign busy      = (state_q != ST_IDLE);
  assign at_target = (state_q == ST_IDLE) && (speed_q == target_q);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// Self-checking bench for fan_ramp_ctrl (RAMP_DIV=4, STEP=4, SPEED_MAX=100).
// Build with FAN_KICK_EN to exercise the kick-start path (KICK_CYCLES=5).
module tb_fan_ramp_ctrl;
  import fan_ctrl_pkg::*;

  localparam int RDIV = 4;
  localparam int STP  = 4;
  localparam int SMAX = 100;
`ifdef FAN_KICK_EN
  localparam int KCYC = 5;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic [11:0] req_speed = '0;
  logic        req_ready;
  logic [11:0] speed;
  logic        busy;
  logic        at_target;
  fan_state_e  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_cur = '0;
  logic [11:0] last_speed = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fan_ramp_ctrl #(
    .RAMP_DIV (RDIV),
    .STEP     (STP),
    .SPEED_MAX(SMAX)
`ifdef FAN_KICK_EN
    ,
    .KICK_CYCLES(KCYC)
`endif
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_speed(req_speed),
    .req_ready(req_ready),
    .speed    (speed),
    .busy     (busy),
    .at_target(at_target),
    .state_dbg(state_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the accepting edge.
  task automatic do_req(input logic [11:0] v);
    @(negedge clk);
    req_valid = 1'b1;
    req_speed = v;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_speed = '0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && busy; k++) wait_edges(1);
    check_eq("idle_timeout", busy, 0);
  endtask

  function automatic logic [11:0] clamp(input logic [11:0] v);
    return (v > 12'(SMAX)) ? 12'(SMAX) : v;
  endfunction

  // Reference model: queue every speed value the DUT should show on its way to tgt.
  task automatic push_path(input logic [11:0] tgt);
`ifdef FAN_KICK_EN
    if (exp_cur == 0 && tgt != 0) begin
      exp_q.push_back(12'(SMAX));
      if (tgt != 12'(SMAX)) exp_q.push_back(tgt);
      exp_cur = tgt;
      return;
    end
`endif
    while (exp_cur != tgt) begin
      if (exp_cur < tgt) exp_cur = ((tgt - exp_cur) > 12'(STP)) ? exp_cur + 12'(STP) : tgt;
      else               exp_cur = ((exp_cur - tgt) > 12'(STP)) ? exp_cur - 12'(STP) : tgt;
      exp_q.push_back(exp_cur);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (speed !== last_speed) begin
      if (exp_q.size() == 0) check_eq("speed_unexpected", speed, last_speed);
      else                   check_eq("speed_seq", speed, exp_q.pop_front());
      check_eq("speed_le_max", (speed > 12'(SMAX)) ? 1 : 0, 0);
      last_speed = speed;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] r;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_speed", speed, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_busy_after", busy, 0);
    check_eq("rst_at_target", at_target, 1);
    check_eq("rst_state", state_dbg, ST_IDLE);

`ifndef FAN_KICK_EN
    // Ramp 0 -> 10: steps at 4, 8, 12 clocks, at_target at 13.
    push_path(12'd10);
    do_req(12'd10);
    check_eq("r10_busy", busy, 1);
    check_eq("r10_e0", speed, 0);
    wait_edges(3);
    check_eq("r10_e3", speed, 0);
    wait_edges(1);
    check_eq("r10_e4", speed, 4);
    wait_edges(4);
    check_eq("r10_e8", speed, 8);
    wait_edges(4);
    check_eq("r10_e12", speed, 10);
    check_eq("r10_e12_at", at_target, 0);
    wait_edges(1);
    check_eq("r10_e13_at", at_target, 1);
    check_eq("r10_e13_busy", busy, 0);

    // Over-range request clamps to SPEED_MAX.
    push_path(clamp(12'd200));
    do_req(12'd200);
    wait_idle();
    check_eq("clamp_speed", speed, SMAX);

    // Request equal to current speed stays idle.
    do_req(12'd100);
    check_eq("eq_busy0", busy, 0);
    wait_edges(3);
    check_eq("eq_busy3", busy, 0);
    check_eq("eq_speed", speed, 100);

    // Redirect mid-ramp: at 8 heading to 40, request 2.
    exp_q.push_back(12'd0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_cur = '0;
    exp_q.push_back(12'd4);
    exp_q.push_back(12'd8);
    do_req(12'd40);
    wait_edges(8);
    check_eq("redir_at8", speed, 8);
    exp_cur = 12'd8;
    push_path(12'd2);
    do_req(12'd2);
    wait_edges(3);
    check_eq("redir_restart", speed, 8);
    wait_edges(1);
    check_eq("redir_s4", speed, 4);
    wait_edges(4);
    check_eq("redir_s2", speed, 2);
    check_eq("redir_busy", busy, 1);
    wait_edges(1);
    check_eq("redir_idle", busy, 0);
    check_eq("redir_at", at_target, 1);
`else
    // Kick start: SPEED_MAX for KICK_CYCLES clocks with req_ready low.
    push_path(12'd30);
    do_req(12'd30);
    check_eq("kick_busy", busy, 1);
    for (int i = 0; i < KCYC; i++) begin
      if (i != 0) wait_edges(1);
      check_eq("kick_speed", speed, SMAX);
      check_eq("kick_ready", req_ready, 0);
    end
    wait_edges(1);
    check_eq("kick_exit_speed", speed, 30);
    check_eq("kick_exit_at", at_target, 1);
    check_eq("kick_exit_ready", req_ready, 1);
`endif

    // Asynchronous reset mid-ramp, then a clean restart.
    exp_q.push_back(exp_cur + 12'(STP));
    exp_q.push_back(12'd0);
    do_req(12'd50);
    wait_edges(5);
    check_eq("abort_pre", speed, exp_cur + 12'(STP));
    rstn = 1'b0;
    #1;
    check_eq("abort_speed", speed, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_state", state_dbg, ST_IDLE);
    @(negedge clk);
    rstn = 1'b1;
    exp_cur = '0;
    push_path(12'd8);
    do_req(12'd8);
    wait_idle();
    check_eq("restart_speed", speed, 8);
    check_eq("restart_at", at_target, 1);

    // Random requests from idle.
    repeat (8) begin
      r = 12'($urandom_range(0, 160));
      push_path(clamp(r));
      do_req(r);
      wait_idle();
      check_eq("rand_speed", speed, exp_cur);
      check_eq("rand_at", at_target, 1);
    end

    wait_edges(2);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fan_ramp_ctrl.md
FAN_RAMP_CTRL -- requirements
Module: fan_ramp_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 2500, meaning clock cycles per ramp step (range 1..65535).
REQ-002 Parameter STEP, default 4, meaning speed increment/decrement per ramp step (range 1..SPEED_MAX).
REQ-003 Parameter SPEED_MAX, default 100, meaning full-scale speed code that the downstream PWM treats as 100 %.
REQ-004 Parameter KICK_CYCLES, default 250000, meaning kick-start duration in clocks (used only with FAN_KICK_EN).
REQ-005 Port clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-006 Port rstn  input  1  reset, asynchronous assert, active-low.
REQ-007 Port req_valid  input  1  new target speed offered.
REQ-008 Port req_speed  input  12  requested target speed code.
REQ-009 Port req_ready  output  1  block can accept a request this cycle.
REQ-010 Port speed  output  12  current speed code driven to the PWM generator.
REQ-011 Port busy  output  1  high whenever the state is not IDLE.
REQ-012 Port at_target  output  1  high when speed equals the latched target and the state is IDLE.

Function
REQ-013 A request SHALL be accepted on a cycle where req_valid and req_ready are both high; target <= min(req_speed, SPEED_MAX).
REQ-014 States SHALL be IDLE, RAMP and KICK (KICK exists only with FAN_KICK_EN).
REQ-015 IDLE -> RAMP on acceptance when the clamped request differs from speed; acceptance of a request equal to speed SHALL leave the state in IDLE.
REQ-016 RAMP SHALL accept a new request at any time; the new target replaces the old one, the ramp direction is re-evaluated, and the step divider restarts from 0.
REQ-017 The step divider SHALL count 0..RAMP_DIV-1 and wrap; a step SHALL fire on the cycle the count equals RAMP_DIV-1 while in RAMP.
REQ-018 On a step: speed <= min(speed+STEP, target) when speed<target; speed <= max(speed-STEP, target) when speed>target; the result SHALL never overshoot or wrap.
REQ-019 RAMP -> IDLE on the cycle after speed reaches target; at_target SHALL rise in that same cycle.
REQ-020 The step divider SHALL hold at 0 in IDLE and KICK.
REQ-021 req_ready SHALL be high in IDLE and RAMP and low in KICK.
REQ-022 speed SHALL be a registered output that changes only on a step, on KICK entry, or on KICK exit.
REQ-023 The minimum first step latency SHALL be RAMP_DIV clocks after acceptance.

Reset
REQ-024 While rstn is low: speed=0, target=0, state=IDLE, divider=0, and kick counter=0; req_ready=1, busy=0 and at_target=1 immediately after deassertion.
REQ-025 Reset asserted mid-ramp or mid-kick SHALL abort the operation with no residual state.

Configuration
REQ-026 With FAN_KICK_EN defined, acceptance while speed==0 of a nonzero clamped target SHALL enter KICK, drive speed=SPEED_MAX for exactly KICK_CYCLES clocks, then load speed=target and go to IDLE.
REQ-027 Without FAN_KICK_EN, the KICK state, the kick counter and KICK_CYCLES logic SHALL be absent, and a start from 0 SHALL ramp normally.

Structure
REQ-028 A shared package fan_ctrl_pkg SHALL hold SPEED_W=12, the state enumeration, and the default values of RAMP_DIV, STEP and SPEED_MAX.
REQ-029 The step divider SHALL be a sub-module ramp_tick_gen with inputs clk, rstn and clear, parameter RAMP_DIV, and output tick.

Verification
REQ-030 RAMP_DIV=4, STEP=4; request 10 from 0 -> speed 4, 8, 10 at clocks 4, 8 and 12 after acceptance; at_target rises at 13.
REQ-031 Request 200 -> target clamps to 100; speed ends at 100 and never exceeds it.
REQ-032 Mid-ramp at speed 8 toward 40, request 2 -> divider restarts; speed goes 4, then 2, then IDLE.
REQ-033 rstn pulled low mid-ramp -> speed=0 and busy=0 asynchronously; the next request starts cleanly.
REQ-034 FAN_KICK_EN, KICK_CYCLES=5, request 30 from 0 -> speed=100 for 5 clocks with req_ready=0, then speed=30 and at_target=1.
REQ-035 Request equal to the current speed -> busy stays 0 and speed is unchanged.
